// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: bounded lo->hi->lo triangular count sweeps, optional one-cycle dwell at hi (SWEEP_DWELL_EN)
module updown_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_lo,
  input  logic [WIDTH-1:0]  cmd_hi,
  input  logic [REPS_W-1:0] cmd_reps,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count_value,
  output logic              flag,
  output logic              busy,
  output logic              done,
  output logic              err
);
`ifdef SWEEP_DWELL_EN
  typedef enum logic [2:0] {IDLE, UP, DOWN, DONE, DWELL} state_t;
`else
  typedef enum logic [2:0] {IDLE, UP, DOWN, DONE} state_t;
`endif
  state_t state;
  logic [WIDTH-1:0] lo, hi;
  logic [REPS_W-1:0] reps;
  assign cmd_ready = state == IDLE;
  // flag stays set into DONE so the final lo value still reads as the tail of the down leg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count_value <= '0;
      lo <= '0;
      hi <= '0;
      reps <= '0;
      flag <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_lo > cmd_hi) err <= 1'b1;
          else begin
            count_value <= cmd_lo;
            lo <= cmd_lo;
            hi <= cmd_hi;
            reps <= cmd_reps;
            if (cmd_reps == '0 || cmd_lo == cmd_hi) state <= DONE;
            else begin
              state <= UP;
              busy <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b1;
          flag <= 1'b0;
        end
        default: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          flag <= 1'b0;
        end else if (!pause) begin
          case (state)
            UP: begin
              count_value <= count_value + WIDTH'(1);
`ifdef SWEEP_DWELL_EN
              if (count_value + WIDTH'(1) == hi) state <= DWELL;
`else
              if (count_value + WIDTH'(1) == hi) begin
                state <= DOWN;
                flag <= 1'b1;
              end
`endif
            end
            DOWN: begin
              count_value <= count_value - WIDTH'(1);
              flag <= 1'b1;
              if (count_value - WIDTH'(1) == lo) begin
                if (reps == REPS_W'(1)) begin
                  state <= DONE;
                  busy <= 1'b0;
                end else begin
                  reps <= reps - REPS_W'(1);
                  state <= UP;
                  flag <= 1'b0;
                end
              end
            end
`ifdef SWEEP_DWELL_EN
            DWELL: state <= DOWN;
`endif
            default: ;
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: directed checks of sweep, pause, abort, reset and illegal/degenerate commands
module tb_updown_sweep_ctrl;
  logic clk, reset, cmd_valid, cmd_ready, pause, abort, flag, busy, done, err;
  logic [3:0] cmd_lo, cmd_hi, cmd_reps, count_value;
  int n_checks = 0, n_fail = 0;
  updown_sweep_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_reps(cmd_reps), .pause(pause),
    .abort(abort), .count_value(count_value), .flag(flag), .busy(busy),
    .done(done), .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] reps);
    cmd_lo = lo;
    cmd_hi = hi;
    cmd_reps = reps;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  function automatic int tri_val(input int p);
    int m;
    m = p % 30;
    return m <= 15 ? m : 30 - m;
  endfunction
  int basic_c[7] = '{2, 3, 4, 5, 4, 3, 2};
  int basic_f[7] = '{0, 0, 0, 1, 1, 1, 1};
  int p, pc;
  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_lo = '0;
    cmd_hi = '0;
    cmd_reps = '0;
    pause = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", count_value, 0);
    check("rst_flag", flag, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);
    send(2, 5, 1);
    for (int i = 0; i < 7; i++) begin
      check("basic_count", count_value, basic_c[i]);
      check("basic_flag", flag, basic_f[i]);
      check("basic_busy", busy, i < 6);
      check("basic_ready", cmd_ready, 0);
      check("basic_done", done, 0);
      @(negedge clk);
    end
    check("basic_done_pulse", done, 1);
    check("basic_end_count", count_value, 2);
    check("basic_end_ready", cmd_ready, 1);
    @(negedge clk);
    check("basic_done_clear", done, 0);
    send(0, 15, 2);
    p = 0;
    pc = 0;
    for (int e = 0; e <= 64; e++) begin
      check("rep_count", count_value, tri_val(p));
      check("rep_flag", flag, (e < 64) && ((p >= 15 && p < 30) || p >= 45));
      check("rep_done", done, e == 64);
      if (p == 9 && pc < 3) begin
        pause = 1'b1;
        pc++;
      end else begin
        pause = 1'b0;
        if (p < 60) p++;
      end
      @(negedge clk);
    end
    pause = 1'b0;
    check("rep_done_clear", done, 0);
    send(7, 3, 1);
    check("ill_err", err, 1);
    check("ill_count", count_value, 0);
    check("ill_ready", cmd_ready, 1);
    check("ill_busy", busy, 0);
    @(negedge clk);
    check("ill_err_clear", err, 0);
    send(4, 4, 3);
    check("eq_count", count_value, 4);
    check("eq_done_early", done, 0);
    check("eq_busy", busy, 0);
    @(negedge clk);
    check("eq_done", done, 1);
    check("eq_ready", cmd_ready, 1);
    send(3, 9, 0);
    check("r0_count", count_value, 3);
    @(negedge clk);
    check("r0_done", done, 1);
    check("r0_end_count", count_value, 3);
    send(2, 10, 1);
    repeat (4) @(negedge clk);
    check("ab_pre_count", count_value, 6);
    abort = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pause = 1'b0;
    check("ab_count", count_value, 6);
    check("ab_ready", cmd_ready, 1);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    @(negedge clk);
    check("ab_no_done", done, 0);
    check("ab_hold", count_value, 6);
    send(0, 5, 1);
    repeat (7) @(negedge clk);
    check("rd_pre_count", count_value, 3);
    check("rd_pre_flag", flag, 1);
    #2 reset = 1'b1;
    #1;
    check("rd_count", count_value, 0);
    check("rd_flag", flag, 0);
    check("rd_busy", busy, 0);
    check("rd_ready", cmd_ready, 1);
    check("rd_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rd_stay_idle", count_value, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
